triadic_thread_issue_sequencer: RTL
===================================

Name: triadic_thread_issue_sequencer

Overview:
- Round-robin barrel-thread sequencer that generates the per-slot IO_Ready and Cancel qualifiers consumed by the Triadic ALU feedback path and its S-register write enable.
- Tracks a small per-thread state machine: disabled, running, IO-stalled, or cancel-pending.
- Also provides the current/next thread numbers, so downstream per-thread storage (S register, PC memory) stays slot-aligned.
- Sits beside the thread-number generator at instruction issue; its outputs travel down the pipeline with the instruction.

Parameters:
- THREAD_COUNT, 8: number of hardware threads; need not be a power of 2; must be ≥2.
- THREAD_COUNT_WIDTH, 3: width of thread number; must satisfy 2**THREAD_COUNT_WIDTH ≥ THREAD_COUNT.
- INITIAL_THREAD, 0: thread number held in slot after reset.
- RETRY_WIDTH, 8: width of per-thread saturating IO-retry counter (optional feature only).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- thread_enable  in  THREAD_COUNT  per-thread run enable; sampled only at that thread's slot.
- io_ready_raw  in  1  IO predicate for the instruction issuing in the current slot.
- branch_cancel  in  1  current-slot instruction annuls the next instruction of the same thread.
- current_thread  out  THREAD_COUNT_WIDTH  thread owning the current slot.
- next_thread  out  THREAD_COUNT_WIDTH  thread owning the following slot.
- IO_Ready  out  1  registered issue qualifier for the previous slot.
- Cancel  out  1  registered annul flag for the previous slot.
- issue_thread  out  THREAD_COUNT_WIDTH  thread that IO_Ready/Cancel refer to.
- thread_stalled  out  THREAD_COUNT  per-thread STALL state indicator.
- retry_overflow  out  1  one-cycle pulse when any retry counter saturates.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Slot counter:
  - current_thread advances by 1 every cycle; THREAD_COUNT-1 wraps to 0.
  - next_thread = (current_thread+1) mod THREAD_COUNT, combinational from the register.
- Per-thread state (2 bits): IDLE, RUN, STALL, CANCEL_ONE.
  - Only the state of current_thread is evaluated and updated each cycle.
- Transitions at thread t's slot, in priority order:
  1. thread_enable[t]=0 → IDLE, from any state.
  2. IDLE with enable=1 → RUN. This slot issues Cancel=1.
  3. CANCEL_ONE → RUN. Slot issues Cancel=1; io_ready_raw and branch_cancel are ignored.
  4. RUN/STALL with io_ready_raw=0 → STALL. Slot issues IO_Ready=0.
  5. RUN/STALL with io_ready_raw=1 and branch_cancel=1 → CANCEL_ONE. Slot issues IO_Ready=1, Cancel=0.
  6. RUN/STALL with io_ready_raw=1 → RUN.
- Output latency: IO_Ready, Cancel and issue_thread are registered, valid 1 cycle after the slot is evaluated. issue_thread equals current_thread of the prior cycle.
- Derived output values:
  - In IDLE and CANCEL_ONE slots, IO_Ready=io_ready_raw is not propagated; IO_Ready=0 and Cancel=1.
  - branch_cancel is ignored when the slot's instruction is already a NOP (IO_Ready=0 or Cancel=1).
  - thread_stalled[t]=1 exactly while state[t]=STALL.
- Reset:
  - current_thread=INITIAL_THREAD, issue_thread=INITIAL_THREAD.
  - IO_Ready=0, Cancel=0, retry_overflow=0.
  - All states=IDLE, retry counters=0.
- Reset asserted mid-run discards any pending CANCEL_ONE and STALL with no residual annul. The first slot after reset release issues Cancel=1 for that thread (IDLE→RUN).

Optional Feature:
- Macro: TRIADIC_SEQ_RETRY_COUNT_EN.
- With the macro defined:
  - Each thread has a RETRY_WIDTH counter, incremented at each of its slots that resolves to STALL.
  - The counter clears on any non-STALL resolution and saturates at all-ones.
  - retry_overflow pulses for 1 cycle, aligned with IO_Ready, on the increment that reaches all-ones. It does not re-pulse while the counter stays saturated.
- Without the macro: no counters are built and retry_overflow is tied to 0.

Decomposition:
- Shared package holds:
  - the 2-bit thread-state enum (IDLE=0, RUN=1, STALL=2, CANCEL_ONE=3);
  - the default THREAD_COUNT and THREAD_COUNT_WIDTH constants.
- One sub-module, triadic_thread_state_slot: the per-thread state register plus its transition logic (and its optional retry counter), instantiated THREAD_COUNT times with a slot-select enable.
- Slot counter and output registers stay in the top level.

Test Plan (THREAD_COUNT=4):
- Reset, then all enables=1 and io_ready_raw=1 → current_thread sequence 0,1,2,3,0. First lap shows Cancel=1 on each thread; second lap shows IO_Ready=1, Cancel=0.
- Thread 2 with io_ready_raw=0 for 3 laps → thread_stalled[2]=1 and IO_Ready=0 on its slots. When io_ready_raw=1, IO_Ready=1 and thread_stalled[2]=0.
- Thread 1 with branch_cancel=1 → its next slot (4 cycles later) shows Cancel=1, IO_Ready=0. The slot after that is normal. Branch_cancel asserted on that cancelled slot is ignored.
- thread_enable[3] dropped mid-STALL → next slot 3 shows Cancel=1, thread_stalled[3]=0. Re-enable → one Cancel=1 slot, then normal issue.
- Reset asserted while thread 0 is in CANCEL_ONE → after release, no lingering annul beyond the IDLE→RUN Cancel slot.
- With TRIADIC_SEQ_RETRY_COUNT_EN and RETRY_WIDTH=2, thread 0 stalled 3 consecutive slots → retry_overflow pulses once on the 3rd stall and stays 0 on the 4th. Without the macro, retry_overflow is always 0.

Source files
------------

// File: rtl/triadic_thread_issue_sequencer_pkg.sv
// Shared thread-state encoding and default sizing for the triadic thread issue sequencer.
package triadic_thread_issue_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RUN        = 2'd1,
        ST_STALL      = 2'd2,
        ST_CANCEL_ONE = 2'd3
    } thread_state_e;

    localparam int DEFAULT_THREAD_COUNT       = 8;
    localparam int DEFAULT_THREAD_COUNT_WIDTH = 3;

endpackage

// File: rtl/triadic_thread_state_slot.sv
// Per-thread issue state and slot qualifiers; evaluated and updated only while slot_sel_i is high.
// TRIADIC_SEQ_RETRY_COUNT_EN adds a saturating stall-retry counter with an overflow flag.
//
// state          | meaning
// ST_IDLE        | thread disabled; its next enabled slot issues a cancelled bubble
// ST_RUN         | thread issuing normally
// ST_STALL       | last slot had io_ready_raw low; instruction retried next lap
// ST_CANCEL_ONE  | branch annulled the thread's next instruction
module triadic_thread_state_slot
    import triadic_thread_issue_sequencer_pkg::*;
`ifdef TRIADIC_SEQ_RETRY_COUNT_EN
#(
    parameter int RETRY_WIDTH = 8
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic slot_sel_i,
    input  logic enable_i,
    input  logic io_ready_raw_i,
    input  logic branch_cancel_i,
    output logic stalled_o,
    output logic io_ready_o,
    output logic cancel_o,
    output logic overflow_o
);

    thread_state_e state_q, state_d;
    logic          io_ready_eval;
    logic          cancel_eval;

    always_comb begin
        state_d       = state_q;
        io_ready_eval = 1'b0;
        cancel_eval   = 1'b0;
        if (!enable_i) begin
            state_d     = ST_IDLE;
            cancel_eval = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_CANCEL_ONE: begin
                    state_d     = ST_RUN;
                    cancel_eval = 1'b1;
                end
                default: begin
                    if (!io_ready_raw_i) begin
                        state_d = ST_STALL;
                    end else begin
                        io_ready_eval = 1'b1;
                        state_d       = branch_cancel_i ? ST_CANCEL_ONE : ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (slot_sel_i) begin
            state_q <= state_d;
        end
    end

    assign stalled_o  = (state_q == ST_STALL);
    assign io_ready_o = slot_sel_i & io_ready_eval;
    assign cancel_o   = slot_sel_i & cancel_eval;

`ifdef TRIADIC_SEQ_RETRY_COUNT_EN
    localparam logic [RETRY_WIDTH-1:0] RETRY_MAX  = '1;
    localparam logic [RETRY_WIDTH-1:0] RETRY_NEAR = RETRY_MAX - RETRY_WIDTH'(1);

    logic [RETRY_WIDTH-1:0] retry_q, retry_d;

    always_comb begin
        retry_d = '0;
        if (state_d == ST_STALL) begin
            retry_d = (retry_q == RETRY_MAX) ? RETRY_MAX : retry_q + RETRY_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retry_q <= '0;
        end else if (slot_sel_i) begin
            retry_q <= retry_d;
        end
    end

    // Only the step from RETRY_NEAR lands on saturation, so a held counter never re-fires.
    assign overflow_o = slot_sel_i && (state_d == ST_STALL) && (retry_q == RETRY_NEAR);
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/triadic_thread_issue_sequencer.sv
// Barrel-thread slot counter plus registered IO_Ready/Cancel issue qualifiers for the Triadic ALU.
// TRIADIC_SEQ_RETRY_COUNT_EN enables per-thread stall-retry counters driving retry_overflow.
module triadic_thread_issue_sequencer
    import triadic_thread_issue_sequencer_pkg::*;
#(
    parameter int THREAD_COUNT       = DEFAULT_THREAD_COUNT,
    parameter int THREAD_COUNT_WIDTH = DEFAULT_THREAD_COUNT_WIDTH,
    parameter int INITIAL_THREAD     = 0,
    parameter int RETRY_WIDTH        = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [THREAD_COUNT-1:0]       thread_enable,
    input  logic                          io_ready_raw,
    input  logic                          branch_cancel,
    output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
    output logic [THREAD_COUNT_WIDTH-1:0] next_thread,
    output logic                          IO_Ready,
    output logic                          Cancel,
    output logic [THREAD_COUNT_WIDTH-1:0] issue_thread,
    output logic [THREAD_COUNT-1:0]       thread_stalled,
    output logic                          retry_overflow
);

    if (THREAD_COUNT < 2) begin : g_bad_thread_count
        $error("THREAD_COUNT must be at least 2");
    end
    if ((2 ** THREAD_COUNT_WIDTH) < THREAD_COUNT) begin : g_bad_thread_width
        $error("THREAD_COUNT_WIDTH too narrow for THREAD_COUNT");
    end
    if (RETRY_WIDTH < 1) begin : g_bad_retry_width
        $error("RETRY_WIDTH must be at least 1");
    end

    localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
    localparam logic [THREAD_COUNT_WIDTH-1:0] INIT_THREAD = THREAD_COUNT_WIDTH'(INITIAL_THREAD);

    logic [THREAD_COUNT_WIDTH-1:0] current_thread_q, current_thread_d;
    logic [THREAD_COUNT_WIDTH-1:0] issue_thread_q;
    logic                          io_ready_q;
    logic                          cancel_q;
    logic                          retry_overflow_q;

    logic [THREAD_COUNT-1:0] slot_sel;
    logic [THREAD_COUNT-1:0] slot_io_ready;
    logic [THREAD_COUNT-1:0] slot_cancel;
    logic [THREAD_COUNT-1:0] slot_overflow;

    assign current_thread_d = (current_thread_q == LAST_THREAD)
                            ? '0 : current_thread_q + THREAD_COUNT_WIDTH'(1);

    for (genvar t = 0; t < THREAD_COUNT; t++) begin : g_slot
        assign slot_sel[t] = (current_thread_q == THREAD_COUNT_WIDTH'(t));

        triadic_thread_state_slot
`ifdef TRIADIC_SEQ_RETRY_COUNT_EN
            #(.RETRY_WIDTH(RETRY_WIDTH))
`endif
        u_slot (
            .clock           (clock),
            .reset           (reset),
            .slot_sel_i      (slot_sel[t]),
            .enable_i        (thread_enable[t]),
            .io_ready_raw_i  (io_ready_raw),
            .branch_cancel_i (branch_cancel),
            .stalled_o       (thread_stalled[t]),
            .io_ready_o      (slot_io_ready[t]),
            .cancel_o        (slot_cancel[t]),
            .overflow_o      (slot_overflow[t])
        );
    end

    // Unselected slots drive zeros, so OR-reduction acts as the current-thread mux.
    always_ff @(posedge clock) begin
        if (reset) begin
            current_thread_q <= INIT_THREAD;
            issue_thread_q   <= INIT_THREAD;
            io_ready_q       <= 1'b0;
            cancel_q         <= 1'b0;
            retry_overflow_q <= 1'b0;
        end else begin
            current_thread_q <= current_thread_d;
            issue_thread_q   <= current_thread_q;
            io_ready_q       <= |slot_io_ready;
            cancel_q         <= |slot_cancel;
            retry_overflow_q <= |slot_overflow;
        end
    end

    assign current_thread = current_thread_q;
    assign next_thread    = current_thread_d;
    assign issue_thread   = issue_thread_q;
    assign IO_Ready       = io_ready_q;
    assign Cancel         = cancel_q;
    assign retry_overflow = retry_overflow_q;

endmodule
